exec_trace_buffer: RTL and testbench

Synthesizable commit-trace capture unit and the hardware successor to the testbench $monitor trace of PC, instruction, register writes and ALU results. It sits beside the datapath and records one entry per retired instruction: PC, instruction, rd write-enable, rd index and write data. Entries go into a parametrised buffer that supports free-run and PC-triggered pre/post capture. Captured entries are drained oldest-first over a valid/ready port, for the bench scoreboard or a debug UART.

---
 rtl/exec_trace_buffer_pkg.sv | 27 ++
 rtl/exec_trace_buffer_if.sv | 36 +++
 rtl/exec_trace_buffer_ram.sv | 24 ++
 rtl/exec_trace_buffer.sv | 138 +++++++++++++
 tb/tb_exec_trace_buffer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_trace_buffer_pkg.sv
// Shared types for the commit-trace buffer: FSM encoding, capture modes
// and the packed trace entry layout.
package trace_pkg;

    localparam int XLEN = 32;
    localparam int IW   = 32;
    localparam int RAW  = 3;

    localparam logic MODE_FREE = 1'b0;
    localparam logic MODE_TRIG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [IW-1:0]   instr;
        logic            rd_we;
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] rd_data;
    } trace_entry_t;

endpackage

// File: rtl/exec_trace_buffer_if.sv
// Commit stream in, drained entries out. master = datapath/consumer side,
// slave = the trace buffer.
interface trace_if
    import trace_pkg::*;
();

    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic [IW-1:0]   commit_instr;
    logic            commit_rd_we;
    logic [RAW-1:0]  commit_rd;
    logic [XLEN-1:0] commit_rd_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [IW-1:0]   out_instr;
    logic            out_rd_we;
    logic [RAW-1:0]  out_rd;
    logic [XLEN-1:0] out_rd_data;

    modport master (
        output commit_valid, commit_pc, commit_instr,
               commit_rd_we, commit_rd, commit_rd_data,
        output out_ready,
        input  out_valid, out_pc, out_instr, out_rd_we, out_rd, out_rd_data
    );

    modport slave (
        input  commit_valid, commit_pc, commit_instr,
               commit_rd_we, commit_rd, commit_rd_data,
        input  out_ready,
        output out_valid, out_pc, out_instr, out_rd_we, out_rd, out_rd_data
    );

endinterface

// File: rtl/exec_trace_buffer_ram.sv
// Trace entry storage: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  trace_entry_t             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output trace_entry_t             rdata
);

    trace_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/exec_trace_buffer.sv
// Commit-trace capture: free-run fill-once or PC-triggered circular capture
// with post-trigger window, drained oldest-first over a valid/ready port.
module exec_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   mode,
    input  logic [XLEN-1:0]        trig_pc,
    trace_if.slave                 bus,
    output logic [1:0]             state,
    output logic [$clog2(DEPTH):0] count,
    output logic                   triggered,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] LAST      = CW'(DEPTH - 1);
    localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

    state_t          st;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   post;
    logic            trig_q;
    logic            ovf_q;
    logic            mode_q;
    logic [XLEN-1:0] trig_pc_q;

    logic            capturing;
    logic            we;
    logic            hit;
    logic            pop;
    trace_entry_t    wentry;
    trace_entry_t    rentry;

    assign capturing = (st == ST_ARMED) || (st == ST_POST);
    assign we        = capturing && bus.commit_valid && !arm;
    assign hit       = (mode_q == MODE_TRIG) && (bus.commit_pc == trig_pc_q);
    assign pop       = bus.out_valid && bus.out_ready && !arm;

    // The oldest entry sits count slots behind the write pointer; this also
    // advances naturally as count drops during drain.
    assign rd_ptr = wr_ptr - cnt[AW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= ST_IDLE;
            cnt       <= '0;
            wr_ptr    <= '0;
            post      <= '0;
            trig_q    <= 1'b0;
            ovf_q     <= 1'b0;
            mode_q    <= MODE_FREE;
            trig_pc_q <= '0;
        end else if (arm) begin
            st        <= ST_ARMED;
            cnt       <= '0;
            wr_ptr    <= '0;
            post      <= '0;
            trig_q    <= 1'b0;
            ovf_q     <= 1'b0;
            mode_q    <= mode;
            trig_pc_q <= trig_pc;
        end else begin
            case (st)
                ST_ARMED, ST_POST: begin
                    if (bus.commit_valid) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (cnt == FULL) ovf_q <= 1'b1;
                        else             cnt   <= cnt + 1'b1;

                        if (st == ST_ARMED) begin
                            if (mode_q == MODE_FREE) begin
                                if (cnt == LAST) st <= ST_DONE;
                            end else if (hit) begin
                                trig_q <= 1'b1;
                                post   <= POST_INIT;
                                st     <= (POST_TRIG == 0) ? ST_DONE : ST_POST;
                            end
                        end else begin
                            post <= post - 1'b1;
                            if (post == AW'(1)) st <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (pop) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) st <= ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wentry = '{
        pc:      bus.commit_pc,
        instr:   bus.commit_instr,
        rd_we:   bus.commit_rd_we,
        rd:      bus.commit_rd,
        rd_data: bus.commit_rd_data
    };

    trace_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (wentry),
        .raddr (rd_ptr),
        .rdata (rentry)
    );

    assign bus.out_valid   = (st == ST_DONE) && (cnt != '0);
    assign bus.out_pc      = rentry.pc;
    assign bus.out_instr   = rentry.instr;
    assign bus.out_rd_we   = rentry.rd_we;
    assign bus.out_rd      = rentry.rd;
    assign bus.out_rd_data = rentry.rd_data;

    assign state     = st;
    assign count     = cnt;
    assign triggered = trig_q;
    assign overflow  = ovf_q;

    a_cnt_bound: assert property (@(posedge clk) disable iff (!reset) cnt <= FULL);
    a_valid_done: assert property (@(posedge clk) disable iff (!reset)
        bus.out_valid |-> (st == ST_DONE));

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Directed bench for exec_trace_buffer: reset, free-run, trigger with/without
// wrap, backpressure and arm-during-drain.
module tb_exec_trace_buffer;
    import trace_pkg::*;

    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 8;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          arm = 1'b0;
    logic          mode = 1'b0;
    logic [31:0]   trig_pc = '0;
    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          triggered;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;

    trace_if bus ();

    exec_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .mode      (mode),
        .trig_pc   (trig_pc),
        .bus       (bus),
        .state     (state),
        .count     (count),
        .triggered (triggered),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] instr,
                          input logic we, input logic [2:0] rd, input logic [31:0] d);
        bus.commit_valid   = 1'b1;
        bus.commit_pc      = pc;
        bus.commit_instr   = instr;
        bus.commit_rd_we   = we;
        bus.commit_rd      = rd;
        bus.commit_rd_data = d;
        cyc();
        bus.commit_valid   = 1'b0;
    endtask

    task automatic do_arm(input logic m, input logic [31:0] tp);
        arm = 1'b1; mode = m; trig_pc = tp;
        cyc();
        arm = 1'b0;
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({state, count, bus.out_valid, triggered, overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_values: got st=%0d cnt=%0d v=%b t=%b o=%b want all 0",
                     state, count, bus.out_valid, triggered, overflow);
        end
        cyc();
        reset = 1'b1;
        cyc();
        commit(32'h10, 32'h13, 1'b0, 3'd0, 32'h0);
        n_cmp++;
        if (state !== 2'd0 || count !== 5'd0) begin
            n_err++;
            $display("FAIL idle_commit_ignored: got st=%0d cnt=%0d want 0/0", state, count);
        end
        do_arm(MODE_FREE, 32'h0);
        for (int i = 0; i < 5; i++) commit(32'(i * 4), 32'h13, 1'b0, 3'd0, 32'h0);
        n_cmp++;
        if (state !== 2'd1 || count !== 5'd5) begin
            n_err++;
            $display("FAIL pre_reset_capture: got st=%0d cnt=%0d want 1/5", state, count);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (state !== 2'd0 || count !== 5'd0) begin
            n_err++;
            $display("FAIL async_reset: got st=%0d cnt=%0d want 0/0", state, count);
        end
        #1 reset = 1'b1;
        cyc();
    endtask

    task automatic test_free_run();
        do_arm(MODE_FREE, 32'h0);
        for (int i = 0; i < 20; i++) begin
            commit(32'(i * 4), 32'h13, 1'b0, 3'd0, 32'h0);
            if (i == 14) begin
                n_cmp++;
                if (state !== 2'd1) begin
                    n_err++;
                    $display("FAIL free_not_done_early: got st=%0d want 1", state);
                end
            end
        end
        n_cmp++;
        if (state !== 2'd3 || count !== 5'd16 || overflow !== 1'b0 || triggered !== 1'b0) begin
            n_err++;
            $display("FAIL free_done: got st=%0d cnt=%0d o=%b t=%b want 3/16/0/0",
                     state, count, overflow, triggered);
        end
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(k * 4)) begin
                n_err++;
                $display("FAIL free_drain[%0d]: got v=%b pc=%h want 1/%h",
                         k, bus.out_valid, bus.out_pc, 32'(k * 4));
            end
            pop();
        end
        n_cmp++;
        if (state !== 2'd0 || bus.out_valid !== 1'b0 || count !== 5'd0) begin
            n_err++;
            $display("FAIL free_idle: got st=%0d v=%b cnt=%0d want 0/0/0",
                     state, bus.out_valid, count);
        end
    endtask

    task automatic test_trigger_wrap();
        do_arm(MODE_TRIG, 32'h40);
        for (int i = 0; i < 28; i++) begin
            commit(32'(i * 4), 32'h13, 1'b0, 3'd0, 32'h0);
            if (i == 15) begin
                n_cmp++;
                if (overflow !== 1'b0 || triggered !== 1'b0 || count !== 5'd16) begin
                    n_err++;
                    $display("FAIL wrap_prefull: got o=%b t=%b cnt=%0d want 0/0/16",
                             overflow, triggered, count);
                end
            end
            if (i == 16) begin
                n_cmp++;
                if (overflow !== 1'b1 || triggered !== 1'b1 || state !== 2'd2) begin
                    n_err++;
                    $display("FAIL wrap_trigger: got o=%b t=%b st=%0d want 1/1/2",
                             overflow, triggered, state);
                end
            end
            if (i == 23) begin
                n_cmp++;
                if (state !== 2'd2) begin
                    n_err++;
                    $display("FAIL wrap_post_window: got st=%0d want 2", state);
                end
            end
        end
        n_cmp++;
        if (state !== 2'd3 || count !== 5'd16) begin
            n_err++;
            $display("FAIL wrap_done: got st=%0d cnt=%0d want 3/16", state, count);
        end
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(32'h24 + k * 4)) begin
                n_err++;
                $display("FAIL wrap_drain[%0d]: got v=%b pc=%h want 1/%h",
                         k, bus.out_valid, bus.out_pc, 32'(32'h24 + k * 4));
            end
            if (k == 7) begin
                n_cmp++;
                if (bus.out_pc !== 32'h40) begin
                    n_err++;
                    $display("FAIL wrap_trig_pos: got pc=%h want 00000040", bus.out_pc);
                end
            end
            pop();
        end
        n_cmp++;
        if (state !== 2'd0 || triggered !== 1'b1 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_sticky: got st=%0d t=%b o=%b want 0/1/1",
                     state, triggered, overflow);
        end
    endtask

    task automatic test_early_trigger();
        do_arm(MODE_TRIG, 32'h08);
        n_cmp++;
        if (triggered !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL arm_clears_flags: got t=%b o=%b want 0/0", triggered, overflow);
        end
        for (int i = 0; i < 13; i++) commit(32'(i * 4), 32'h13, 1'b0, 3'd0, 32'h0);
        n_cmp++;
        if (state !== 2'd3 || count !== 5'd11 || overflow !== 1'b0 || triggered !== 1'b1) begin
            n_err++;
            $display("FAIL early_done: got st=%0d cnt=%0d o=%b t=%b want 3/11/0/1",
                     state, count, overflow, triggered);
        end
        for (int k = 0; k < 11; k++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(k * 4)) begin
                n_err++;
                $display("FAIL early_drain[%0d]: got v=%b pc=%h want 1/%h",
                         k, bus.out_valid, bus.out_pc, 32'(k * 4));
            end
            pop();
        end
        n_cmp++;
        if (state !== 2'd0) begin
            n_err++;
            $display("FAIL early_idle: got st=%0d want 0", state);
        end
    endtask

    task automatic test_backpressure();
        logic [100:0] exp0;
        exp0 = {32'h0, 32'h00312023, 1'b1, 3'd3, 32'hDEADBEEF};
        do_arm(MODE_FREE, 32'h0);
        commit(32'h0, 32'h00312023, 1'b1, 3'd3, 32'hDEADBEEF);
        for (int i = 1; i < 16; i++)
            commit(32'(i * 4), 32'hA5000000 | 32'(i), i[0], i[2:0], 32'(32'h1000 + i));
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 ||
                {bus.out_pc, bus.out_instr, bus.out_rd_we, bus.out_rd, bus.out_rd_data} !== exp0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b pc=%h ins=%h we=%b rd=%0d d=%h want 1/0/00312023/1/3/deadbeef",
                         c, bus.out_valid, bus.out_pc, bus.out_instr, bus.out_rd_we,
                         bus.out_rd, bus.out_rd_data);
            end
            cyc();
        end
        n_cmp++;
        if (count !== 5'd16) begin
            n_err++;
            $display("FAIL bp_count: got %0d want 16", count);
        end
        pop();
        n_cmp++;
        if (count !== 5'd15 || bus.out_pc !== 32'h4 || bus.out_instr !== 32'hA5000001 ||
            bus.out_rd_we !== 1'b1 || bus.out_rd !== 3'd1 || bus.out_rd_data !== 32'h1001) begin
            n_err++;
            $display("FAIL bp_second: got cnt=%0d pc=%h ins=%h we=%b rd=%0d d=%h want 15/4/a5000001/1/1/1001",
                     count, bus.out_pc, bus.out_instr, bus.out_rd_we, bus.out_rd, bus.out_rd_data);
        end
    endtask

    task automatic test_arm_during_drain();
        pop();
        pop();
        n_cmp++;
        if (count !== 5'd13 || bus.out_pc !== 32'hC) begin
            n_err++;
            $display("FAIL add_three_pops: got cnt=%0d pc=%h want 13/c", count, bus.out_pc);
        end
        arm = 1'b1; mode = MODE_FREE; trig_pc = 32'h0;
        bus.out_ready = 1'b1;
        bus.commit_valid = 1'b1; bus.commit_pc = 32'hBAD0;
        cyc();
        arm = 1'b0; bus.out_ready = 1'b0; bus.commit_valid = 1'b0;
        n_cmp++;
        if (state !== 2'd1 || count !== 5'd0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL add_arm_wins: got st=%0d cnt=%0d v=%b want 1/0/0",
                     state, count, bus.out_valid);
        end
        for (int i = 0; i < 16; i++)
            commit(32'(32'h100 + i * 4), 32'h13, 1'b0, 3'd0, 32'h0);
        n_cmp++;
        if (state !== 2'd3 || count !== 5'd16) begin
            n_err++;
            $display("FAIL add_refill: got st=%0d cnt=%0d want 3/16", state, count);
        end
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(32'h100 + k * 4)) begin
                n_err++;
                $display("FAIL add_drain[%0d]: got v=%b pc=%h want 1/%h",
                         k, bus.out_valid, bus.out_pc, 32'(32'h100 + k * 4));
            end
            pop();
        end
        n_cmp++;
        if (state !== 2'd0) begin
            n_err++;
            $display("FAIL add_idle: got st=%0d want 0", state);
        end
    endtask

    initial begin
        bus.commit_valid   = 1'b0;
        bus.commit_pc      = '0;
        bus.commit_instr   = '0;
        bus.commit_rd_we   = 1'b0;
        bus.commit_rd      = '0;
        bus.commit_rd_data = '0;
        bus.out_ready      = 1'b0;
        test_reset();
        test_free_run();
        test_trigger_wrap();
        test_early_trigger();
        test_backpressure();
        test_arm_during_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
